// File: rtl/pupil_locator.sv
// pupil_locator
//   Finds the bounding box, centre and size of the dark region in one video
//   frame. A pixel is dark when its intensity is strictly below iTHRESH.
//   Results are registered once per complete frame and announced with a
//   single-cycle oVALID pulse; they hold their value until the next report.
//
// Ports
//   iCLK                 clock, rising edge
//   iRST                 asynchronous reset, active low
//   iDVAL                pixel valid
//   iDATA[9:0]           pixel intensity
//   iSOF                 start of frame; coincident or next valid pixel is (0,0)
//   iTHRESH[9:0]         dark threshold, sampled with every pixel
//   oX_MIN/oX_MAX[9:0]   horizontal extent of the dark pixels
//   oY_MIN/oY_MAX[9:0]   vertical extent of the dark pixels
//   oX_CENTER/oY_CENTER  bounding-box centre
//   oPIX_COUNT[18:0]     number of dark pixels in the last frame
//   oFOUND               oPIX_COUNT >= MIN_COUNT
//   oVALID               one-cycle pulse, results just updated
module pupil_locator #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int MIN_COUNT = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iDVAL,
    input  logic [9:0]  iDATA,
    input  logic        iSOF,
    input  logic [9:0]  iTHRESH,
    output logic [9:0]  oX_MIN,
    output logic [9:0]  oX_MAX,
    output logic [9:0]  oY_MIN,
    output logic [9:0]  oY_MAX,
    output logic [9:0]  oX_CENTER,
    output logic [9:0]  oY_CENTER,
    output logic [18:0] oPIX_COUNT,
    output logic        oFOUND,
    output logic        oVALID
);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        REPORT   = 2'd2
    } state_t;

    localparam logic [9:0]  X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST = 10'(V_ACTIVE - 1);
    localparam logic [18:0] CNT_MIN = 19'(MIN_COUNT);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  xmin_q, xmin_d, xmax_q, xmax_d;
    logic [9:0]  ymin_q, ymin_d, ymax_q, ymax_d;
    logic [18:0] cnt_q, cnt_d;

    logic [9:0]  res_xmin_q, res_xmax_q, res_ymin_q, res_ymax_q;
    logic [9:0]  res_xc_q, res_yc_q;
    logic [18:0] res_cnt_q;
    logic        res_found_q, res_vld_q;

    // Accumulator values the current pixel is applied to: iSOF restarts the
    // frame in the same cycle so a coincident pixel lands on (0,0).
    logic [9:0]  x_b, y_b, xmin_b, xmax_b, ymin_b, ymax_b;
    logic [18:0] cnt_b;
    logic        take, dark, last, found_d;
    logic [10:0] xsum, ysum;
    logic [9:0]  xc_d, yc_d;

    always_comb begin
        x_b    = x_q;
        y_b    = y_q;
        cnt_b  = cnt_q;
        xmin_b = xmin_q;
        xmax_b = xmax_q;
        ymin_b = ymin_q;
        ymax_b = ymax_q;
        if (iSOF) begin
            x_b    = '0;
            y_b    = '0;
            cnt_b  = '0;
            xmin_b = '1;
            xmax_b = '0;
            ymin_b = '1;
            ymax_b = '0;
        end

        take = iDVAL && (iSOF || (state_q == ACCUM));
        dark = iDATA < iTHRESH;
        last = take && (x_b == X_LAST) && (y_b == Y_LAST);

        x_d    = x_b;
        y_d    = y_b;
        cnt_d  = cnt_b;
        xmin_d = xmin_b;
        xmax_d = xmax_b;
        ymin_d = ymin_b;
        ymax_d = ymax_b;
        if (take) begin
            if (x_b == X_LAST) begin
                x_d = '0;
                y_d = y_b + 10'd1;
            end else begin
                x_d = x_b + 10'd1;
            end
            if (dark) begin
                cnt_d = cnt_b + 19'd1;
                if (x_b < xmin_b) xmin_d = x_b;
                if (x_b > xmax_b) xmax_d = x_b;
                if (y_b < ymin_b) ymin_d = y_b;
                if (y_b > ymax_b) ymax_d = y_b;
            end
        end

        state_d = state_q;
        case (state_q)
            WAIT_SOF: if (iSOF) state_d = ACCUM;
            ACCUM:    state_d = ACCUM;
            REPORT:   state_d = iSOF ? ACCUM : WAIT_SOF;
            default:  state_d = WAIT_SOF;
        endcase
        if (last) state_d = REPORT;

        // 11-bit sums keep the carry so the centre never wraps.
        xsum    = {1'b0, xmin_d} + {1'b0, xmax_d};
        ysum    = {1'b0, ymin_d} + {1'b0, ymax_d};
        xc_d    = 10'(xsum >> 1);
        yc_d    = 10'(ysum >> 1);
        found_d = cnt_d >= CNT_MIN;
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q     <= WAIT_SOF;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            res_xmin_q  <= '0;
            res_xmax_q  <= '0;
            res_ymin_q  <= '0;
            res_ymax_q  <= '0;
            res_xc_q    <= '0;
            res_yc_q    <= '0;
            res_cnt_q   <= '0;
            res_found_q <= 1'b0;
            res_vld_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            xmin_q    <= xmin_d;
            xmax_q    <= xmax_d;
            ymin_q    <= ymin_d;
            ymax_q    <= ymax_d;
            res_vld_q <= last;
            if (last) begin
                res_cnt_q   <= cnt_d;
                res_found_q <= found_d;
                // Coordinates are only meaningful for a confirmed detection.
                res_xmin_q  <= found_d ? xmin_d : '0;
                res_xmax_q  <= found_d ? xmax_d : '0;
                res_ymin_q  <= found_d ? ymin_d : '0;
                res_ymax_q  <= found_d ? ymax_d : '0;
                res_xc_q    <= found_d ? xc_d   : '0;
                res_yc_q    <= found_d ? yc_d   : '0;
            end
        end
    end

    assign oX_MIN     = res_xmin_q;
    assign oX_MAX     = res_xmax_q;
    assign oY_MIN     = res_ymin_q;
    assign oY_MAX     = res_ymax_q;
    assign oX_CENTER  = res_xc_q;
    assign oY_CENTER  = res_yc_q;
    assign oPIX_COUNT = res_cnt_q;
    assign oFOUND     = res_found_q;
    assign oVALID     = res_vld_q;

endmodule

// File: tb/tb_pupil_locator.sv
// Bench for pupil_locator with an 8x4 frame. Two instances share stimulus:
// one with MIN_COUNT=2 and one with MIN_COUNT=1.
module tb_pupil_locator;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dval = 1'b0;
    logic        sof = 1'b0;
    logic [9:0]  data = '0;
    logic [9:0]  thr = '0;

    logic [9:0]  a_xmin, a_xmax, a_ymin, a_ymax, a_xc, a_yc;
    logic [18:0] a_cnt;
    logic        a_found, a_vld;
    logic [9:0]  b_xmin, b_xmax, b_ymin, b_ymax, b_xc, b_yc;
    logic [18:0] b_cnt;
    logic        b_found, b_vld;

    always #5 clk = ~clk;

    pupil_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(2)) dut0 (
        .iCLK(clk), .iRST(rst_n), .iDVAL(dval), .iDATA(data), .iSOF(sof),
        .iTHRESH(thr), .oX_MIN(a_xmin), .oX_MAX(a_xmax), .oY_MIN(a_ymin),
        .oY_MAX(a_ymax), .oX_CENTER(a_xc), .oY_CENTER(a_yc),
        .oPIX_COUNT(a_cnt), .oFOUND(a_found), .oVALID(a_vld)
    );

    pupil_locator #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(1)) dut1 (
        .iCLK(clk), .iRST(rst_n), .iDVAL(dval), .iDATA(data), .iSOF(sof),
        .iTHRESH(thr), .oX_MIN(b_xmin), .oX_MAX(b_xmax), .oY_MIN(b_ymin),
        .oY_MAX(b_ymax), .oX_CENTER(b_xc), .oY_CENTER(b_yc),
        .oPIX_COUNT(b_cnt), .oFOUND(b_found), .oVALID(b_vld)
    );

    typedef struct {
        logic [9:0]  xmin, xmax, ymin, ymax, xc, yc;
        logic [18:0] cnt;
        logic        found;
        int          cyc;
    } res_t;

    res_t q0[$];
    res_t q1[$];
    res_t last0, last1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state: the dark flags of the pixels accepted so far in
    // the frame that is currently open.
    bit   frame_on = 1'b0;
    bit   pix_dark[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic res_t zero_res();
        res_t r;
        r.xmin = '0; r.xmax = '0; r.ymin = '0; r.ymax = '0;
        r.xc = '0; r.yc = '0; r.cnt = '0; r.found = 1'b0; r.cyc = 0;
        return r;
    endfunction

    // Expected report derived from the list of dark flags in raster order.
    function automatic res_t model(input int minc, input int c);
        res_t r;
        int n = 0;
        int xmn = 1 << 20, xmx = -1, ymn = 1 << 20, ymx = -1;
        r = zero_res();
        foreach (pix_dark[i]) begin
            if (pix_dark[i]) begin
                n++;
                if (i % H < xmn) xmn = i % H;
                if (i % H > xmx) xmx = i % H;
                if (i / H < ymn) ymn = i / H;
                if (i / H > ymx) ymx = i / H;
            end
        end
        r.cnt   = 19'(n);
        r.found = (n >= minc);
        if (r.found && n > 0) begin
            r.xmin = 10'(xmn); r.xmax = 10'(xmx);
            r.ymin = 10'(ymn); r.ymax = 10'(ymx);
            r.xc = 10'((xmn + xmx) / 2);
            r.yc = 10'((ymn + ymx) / 2);
        end
        r.cyc = c;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_res(input string who, input res_t act, input res_t exp);
        chk({who, "_xmin"},  32'(act.xmin),  32'(exp.xmin));
        chk({who, "_xmax"},  32'(act.xmax),  32'(exp.xmax));
        chk({who, "_ymin"},  32'(act.ymin),  32'(exp.ymin));
        chk({who, "_ymax"},  32'(act.ymax),  32'(exp.ymax));
        chk({who, "_xc"},    32'(act.xc),    32'(exp.xc));
        chk({who, "_yc"},    32'(act.yc),    32'(exp.yc));
        chk({who, "_count"}, 32'(act.cnt),   32'(exp.cnt));
        chk({who, "_found"}, 32'(act.found), 32'(exp.found));
    endtask

    // Monitor: pops on every oVALID, otherwise checks that results hold.
    res_t m0, m1, e0, e1;
    always @(negedge clk) begin
        m0 = zero_res();
        m0.xmin = a_xmin; m0.xmax = a_xmax; m0.ymin = a_ymin; m0.ymax = a_ymax;
        m0.xc = a_xc; m0.yc = a_yc; m0.cnt = a_cnt; m0.found = a_found;
        m1 = zero_res();
        m1.xmin = b_xmin; m1.xmax = b_xmax; m1.ymin = b_ymin; m1.ymax = b_ymax;
        m1.xc = b_xc; m1.yc = b_yc; m1.cnt = b_cnt; m1.found = b_found;

        if (q0.size() > 0 && q0[0].cyc < cyc) begin
            e0 = q0.pop_front();
            checks++; errors++;
            $display("FAIL dut0_missing_valid actual=none required=cycle %0d", e0.cyc);
        end
        if (q1.size() > 0 && q1[0].cyc < cyc) begin
            e1 = q1.pop_front();
            checks++; errors++;
            $display("FAIL dut1_missing_valid actual=none required=cycle %0d", e1.cyc);
        end

        if (a_vld) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("dut0_latency", cyc, e0.cyc);
                cmp_res("dut0", m0, e0);
                last0 = e0;
            end
        end else begin
            cmp_res("dut0_hold", m0, last0);
        end

        if (b_vld) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_valid actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_latency", cyc, e1.cyc);
                cmp_res("dut1", m1, e1);
                last1 = e1;
            end
        end else begin
            cmp_res("dut1_hold", m1, last1);
        end
    end

    // Drive one cycle and advance the reference model.
    task automatic drive(input bit s, input bit v, input logic [9:0] d, input logic [9:0] t);
        @(negedge clk);
        sof = s; dval = v; data = d; thr = t;
        if (s) begin
            frame_on = 1'b1;
            pix_dark.delete();
        end
        if (v && frame_on) begin
            pix_dark.push_back(d < t);
            if (pix_dark.size() == NPIX) begin
                q0.push_back(model(2, cyc + 1));
                q1.push_back(model(1, cyc + 1));
                frame_on = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 10'd0, 10'd0);
    endtask

    // kind 0: square blob, 1: all equal to threshold, 2: single dark at (7,3)
    function automatic logic [9:0] pix_val(input int kind, input int x, input int y);
        case (kind)
            0:       return (x >= 2 && x <= 4 && y >= 1 && y <= 2) ? 10'd50 : 10'd500;
            1:       return 10'd100;
            default: return (x == 7 && y == 3) ? 10'd50 : 10'd500;
        endcase
    endfunction

    task automatic send_frame(input int kind, input bit bubbles, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (bubbles && i > 0) drive(0, 0, 10'd0, 10'd100);
            drive(i == 0, 1, pix_val(kind, i % H, i / H), 10'd100);
        end
    endtask

    task automatic reset_pulse(input int n);
        @(posedge clk); #2;
        rst_n = 1'b0;
        frame_on = 1'b0;
        pix_dark.delete();
        last0 = zero_res();
        last1 = zero_res();
        idle(n);
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic rand_frame();
        int sent;
        bit first;
        logic [9:0] t, d;
        int off;
        t = 10'($urandom_range(0, 1023));
        if ($urandom_range(0, 4) == 0) begin
            // partial frame that a later iSOF aborts
            for (int i = 0; i < int'($urandom_range(1, NPIX - 1)); i++)
                drive(i == 0, 1, 10'($urandom_range(0, 1023)), t);
        end
        first = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            drive(1, 0, 10'd0, t);
            first = 1'b0;
        end
        sent = 0;
        while (sent < NPIX) begin
            if ($urandom_range(0, 3) == 0) begin
                drive(0, 0, 10'($urandom_range(0, 1023)), t);
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    off = int'(t) + int'($urandom_range(0, 16)) - 8;
                    if (off < 0) off = 0;
                    if (off > 1023) off = 1023;
                    d = 10'(off);
                end else begin
                    d = 10'($urandom_range(0, 1023));
                end
                drive(first, 1, d, t);
                first = 1'b0;
                sent++;
            end
        end
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    endtask

    initial begin
        last0 = zero_res();
        last1 = zero_res();
        idle(3);
        chk("reset_valid0", 32'(a_vld), 32'd0);
        chk("reset_count0", 32'(a_cnt), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(2);

        // pixels without any iSOF must be ignored
        for (int i = 0; i < NPIX; i++) drive(0, 1, 10'd0, 10'd100);
        idle(2);

        send_frame(0, 1'b0, NPIX);   // square blob
        idle(2);
        send_frame(1, 1'b0, NPIX);   // equality edge
        idle(2);
        send_frame(2, 1'b0, NPIX);   // single dark pixel at (7,3)
        idle(2);
        send_frame(0, 1'b1, NPIX);   // blob with bubbles
        idle(2);
        send_frame(0, 1'b0, 20);     // aborted partial frame
        send_frame(0, 1'b0, NPIX);
        send_frame(2, 1'b0, NPIX);   // back-to-back, SOF during report cycle
        idle(2);

        send_frame(0, 1'b0, 10);     // reset mid-frame
        reset_pulse(3);
        chk("midrst_valid0", 32'(a_vld), 32'd0);
        chk("midrst_count0", 32'(a_cnt), 32'd0);
        for (int i = 0; i < NPIX; i++) drive(0, 1, pix_val(0, i % H, i / H), 10'd100);
        idle(2);
        send_frame(0, 1'b0, NPIX);
        idle(2);

        repeat (30) rand_frame();
        idle(4);

        chk("queue0_drained", 32'(q0.size()), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
